// File: rtl/shift_reg_unit_if.sv
// Operand register bus: load/shift request signals toward the unit and
// register contents plus status flags back from it.
interface shift_reg_unit_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
);
  logic               load;
  logic [WIDTH-1:0]   A;
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   Q;
  logic               busy;
  logic               done;
  logic               carry;
  logic               zero;

  modport master (output load, A, start, op, amt,
                  input  Q, busy, done, carry, zero);
  modport slave  (input  load, A, start, op, amt,
                  output Q, busy, done, carry, zero);
endinterface

// File: rtl/shift_reg_unit.sv
// WIDTH-bit operand register with parallel load and bit-serial shift/rotate
// (one bit per enabled clock) under a start/busy/done handshake.
module shift_reg_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  shift_reg_unit_if.slave  bus
);
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   q, q_nxt, q_step;
  logic               carry, carry_nxt, c_step;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic [2:0]         op_r, op_nxt;

  // Single 1-bit step of the latched operation.
  always_comb begin
    q_step = q;
    c_step = 1'b0;
    case (op_r)
      OP_SLL: begin c_step = q[WIDTH-1]; q_step = {q[WIDTH-2:0], 1'b0};      end
      OP_SRL: begin c_step = q[0];       q_step = {1'b0, q[WIDTH-1:1]};      end
      OP_SRA: begin c_step = q[0];       q_step = {q[WIDTH-1], q[WIDTH-1:1]}; end
      OP_ROL: begin c_step = q[WIDTH-1]; q_step = {q[WIDTH-2:0], q[WIDTH-1]}; end
      OP_ROR: begin c_step = q[0];       q_step = {q[0], q[WIDTH-1:1]};      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    op_nxt    = op_r;
    case (state)
      IDLE: begin
        if (bus.load) begin
          q_nxt     = bus.A;
          carry_nxt = 1'b0;
        end else if (bus.start) begin
          if (bus.op <= OP_ROR && bus.amt != '0) begin
            op_nxt    = bus.op;
            cnt_nxt   = bus.amt;
            state_nxt = SHIFT;
          end else begin
            // Zero amount or reserved op completes immediately as a no-op.
            carry_nxt = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        q_nxt     = q_step;
        carry_nxt = c_step;
        cnt_nxt   = cnt - 1'b1;
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      op_r  <= '0;
    end else if (en) begin
      state <= state_nxt;
      q     <= q_nxt;
      carry <= carry_nxt;
      cnt   <= cnt_nxt;
      op_r  <= op_nxt;
    end
  end

  assign bus.Q     = q;
  assign bus.carry = carry;
  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);
  assign bus.zero  = (q == '0);
endmodule

// File: doc/shift_reg_unit.md
Name: shift_reg_unit

Overview:
Parametrised successor to the 8-bit enabled data register: a WIDTH-bit operand register with parallel load plus multi-cycle shift/rotate operations. Each shift runs one bit per clock under a start/busy/done handshake. It provides carry-out and zero flags to the calculator datapath and control FSM. It sits between the operand input bus and the ALU, and replaces plain register instances where shift operators are needed.

Parameters:
WIDTH, 8, data width in bits (>=2)
SHAMT_W, $clog2(WIDTH)+1, width of shift-amount input (amounts 0..2^SHAMT_W-1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  global clock enable; when 0 all state (Q, FSM, counter, flags) holds
load  input  1  parallel load request
A  input  WIDTH  parallel load data
start  input  1  begin shift operation
op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved
amt  input  SHAMT_W  shift amount in bits
Q  output  WIDTH  register contents
busy  output  1  high while shifting
done  output  1  one-cycle completion pulse
carry  output  1  last bit shifted/rotated out
zero  output  1  Q == 0 (combinational)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low on rst_n and sampled on the rising edge. Reset overrides en.
- Reset values: Q=0, carry=0, FSM=IDLE, busy=0, done=0; zero=1 as a consequence.
- Clock enable: every action below occurs only on edges with en=1 and rst_n=1.
- FSM states: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE).
- IDLE priority: load > start.
  - load=1: Q<=A, carry<=0, stay IDLE.
  - start=1 with valid op and amt>=1: latch op, cnt<=amt, go to SHIFT; Q unchanged on this edge.
  - start=1 with amt=0 or reserved op: go to DONE; Q unchanged, carry<=0.
- SHIFT: each edge performs one 1-bit step of the latched op and sets cnt<=cnt-1. On the edge where cnt==1, the last step is performed and state goes to DONE.
- Step definitions:
  - SLL: carry<=Q[W-1], Q<={Q[W-2:0],0}.
  - SRL: carry<=Q[0], Q<={0,Q[W-1:1]}.
  - SRA: carry<=Q[0], Q<={Q[W-1],Q[W-1:1]}.
  - ROL: carry<=Q[W-1], Q<={Q[W-2:0],Q[W-1]}.
  - ROR: carry<=Q[0], Q<={Q[0],Q[W-1:1]}.
- DONE: lasts exactly one enabled cycle, then returns to IDLE. load and start are ignored in DONE.
- Latency: for amt=N>=1, busy is high for N enabled cycles after the start edge, and done is high in the (N+1)th cycle. For amt=0, done is high in the cycle after the start edge and busy never rises.
- Amounts >= WIDTH are executed bit by bit with no saturation:
  - SLL/SRL results are 0.
  - SRA result is all copies of the sign bit.
  - Rotates are modulo WIDTH in effect.
- load and start in SHIFT or DONE are ignored, with no queuing. Inputs op and amt are don't-care after the start edge.
- en=0 mid-SHIFT freezes cnt and Q and stretches busy. Operation resumes when en returns to 1.
- rst_n=0 mid-operation aborts the shift and applies the reset values on that edge. No done pulse is issued.

Test Plan:
- Reset/load: rst_n=0 for 1 edge -> Q=0x00, busy=0, done=0, carry=0, zero=1. Then load=1, A=0xA5, en=1 -> Q=0xA5, zero=0. Repeat with en=0, A=0x3C -> Q stays 0xA5.
- SRA: Q=0x96, start, op=010, amt=3 -> busy high 3 cycles, done pulse in cycle 4, Q=0xF2, carry=1.
- ROL wrap: Q=0x81, op=011, amt=9 -> busy high 9 cycles, then Q=0x03, carry=1. SLL amt=8 on 0xFF -> Q=0x00, carry=1, zero=1.
- Ignored requests: during a 4-bit SRL of 0xF0, assert load A=0x11 and start -> both ignored, final Q=0x0F, carry=0. Single done pulse only.
- Zero/reserved amount: start, amt=0, Q=0x5A -> done next cycle, busy never high, Q=0x5A, carry=0. op=110, amt=5 -> same response.
- Enable stall and abort: SLL amt=4 on 0x01 with en low for 2 cycles mid-shift -> busy high 6 cycles, Q=0x10. Second run: rst_n=0 after 2 steps -> Q=0x00, IDLE, no done pulse.
